// File: rtl/hs_pkg.sv
// Shared definitions for the hs_pipe handshake pipeline: default
// parameters and a constant-evaluable ceil(log2) helper used to size
// the occupancy counter.
package hs_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int STAGES_DEF = 2;

    // Number of bits needed to encode values 0 .. value-1.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/hs_skid_slice.sv
// One fully registered valid/ready slice. A main register feeds the
// output; a skid register catches the single word that can arrive in the
// cycle after the downstream stalls, because in_ready is taken from a
// flop (~skid_v) rather than from out_ready.
module hs_skid_slice
    import hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready
);

    logic              main_v_reg, main_v_next;
    logic              skid_v_reg, skid_v_next;
    logic [DATA_W-1:0] main_d_reg, main_d_next;
    logic [DATA_W-1:0] skid_d_reg, skid_d_next;
    logic              accept;
    logic              emit;

    assign in_ready  = ~skid_v_reg;
    assign out_valid = main_v_reg;
    assign out_data  = main_d_reg;
    assign accept    = in_valid & ~skid_v_reg;
    assign emit      = main_v_reg & out_ready;

    // Next-state: refill main from skid first (keeps FIFO order), else from
    // the input; park the input in skid only when main is blocked.
    always_comb begin
        main_v_next = main_v_reg;
        main_d_next = main_d_reg;
        skid_v_next = skid_v_reg;
        skid_d_next = skid_d_reg;
        if (!main_v_reg || emit) begin
            if (skid_v_reg) begin
                main_v_next = 1'b1;
                main_d_next = skid_d_reg;
                skid_v_next = 1'b0;
            end else if (accept) begin
                main_v_next = 1'b1;
                main_d_next = in_data;
            end else begin
                main_v_next = 1'b0;
            end
        end else if (accept) begin
            skid_v_next = 1'b1;
            skid_d_next = in_data;
        end
    end

    // Valid flags: cleared by reset or flush, otherwise follow next-state.
    always_ff @(posedge sys_clk) begin
        if (rst || flush) begin
            main_v_reg <= 1'b0;
            skid_v_reg <= 1'b0;
        end else begin
            main_v_reg <= main_v_next;
            skid_v_reg <= skid_v_next;
        end
    end

    // Payload registers carry no reset; their content is qualified by the flags.
    always_ff @(posedge sys_clk) begin
        main_d_reg <= main_d_next;
        skid_d_reg <= skid_d_next;
    end

endmodule

// File: rtl/hs_pipe.sv
// Chain of STAGES skid slices with registered valid, data and ready at
// every stage, plus a registered count of words held in the chain.
module hs_pipe
    import hs_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int STAGES = STAGES_DEF,
    parameter int CNT_W  = clog2(2 * STAGES + 1)
) (
    input  logic              sys_clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              s_valid,
    input  logic [DATA_W-1:0] s_data,
    output logic              s_ready,
    output logic              m_valid,
    output logic [DATA_W-1:0] m_data,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  occupancy
);

    // Link k is the boundary between slice k-1 and slice k; link 0 is the
    // upstream port and link STAGES is the downstream port.
    logic [STAGES:0]   valid_link;
    logic [STAGES:0]   ready_link;
    logic [DATA_W-1:0] data_link [STAGES+1];

    logic              in_hs;
    logic              out_hs;
    logic [CNT_W-1:0]  occ_reg, occ_next;

    assign valid_link[0]      = s_valid;
    assign data_link[0]       = s_data;
    assign s_ready            = ready_link[0];
    assign m_valid            = valid_link[STAGES];
    assign m_data             = data_link[STAGES];
    assign ready_link[STAGES] = m_ready;

    generate
        for (genvar gi = 0; gi < STAGES; gi++) begin : g_slice
            hs_skid_slice #(
                .DATA_W (DATA_W)
            ) u_slice (
                .sys_clk   (sys_clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (valid_link[gi]),
                .in_data   (data_link[gi]),
                .in_ready  (ready_link[gi]),
                .out_valid (valid_link[gi+1]),
                .out_data  (data_link[gi+1]),
                .out_ready (ready_link[gi+1])
            );
        end
    endgenerate

    assign in_hs     = s_valid & s_ready;
    assign out_hs    = m_valid & m_ready;
    assign occupancy = occ_reg;

    // Words enter only at slice 0 and leave only at the last slice, so the
    // port handshakes alone track the total number of set valid flags.
    always_comb begin
        occ_next = occ_reg + {{(CNT_W-1){1'b0}}, in_hs} - {{(CNT_W-1){1'b0}}, out_hs};
    end

    // Occupancy register, emptied together with the slices.
    always_ff @(posedge sys_clk) begin
        if (rst || flush) begin
            occ_reg <= '0;
        end else begin
            occ_reg <= occ_next;
        end
    end

endmodule

// File: tb/tb_hs_pipe.sv
// Scoreboard bench for hs_pipe. Instance 0 uses STAGES=2 for the directed
// scenarios; instances 1 (STAGES=1) and 2 (STAGES=4) take random traffic.
// Accepted words are queued per instance; a per-instance monitor pops and
// compares on every output handshake and tracks an occupancy model.
`timescale 1ns/1ps
module tb_hs_pipe;

    localparam int NI = 3;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [NI-1:0]   s_valid = '0;
    logic [NI-1:0]   flush   = '0;
    logic [NI-1:0]   m_ready = '0;
    logic [7:0]      s_data [NI];
    logic [NI-1:0]   s_ready;
    logic [NI-1:0]   m_valid;
    logic [7:0]      m_data [NI];
    logic [3:0]      occ    [NI];
    logic [NI-1:0]   src_done = '0;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s inst %0d: got %0d, expected %0d", nm, inst, act, exp);
        end
    endtask

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int ST = (gi == 0) ? 2 : (gi == 1) ? 1 : 4;
            localparam int CW = $clog2(2 * ST + 1);
            logic [CW-1:0] occ_w;
            logic          sr, mv;
            logic [7:0]    md;
            logic [7:0]    exp_q [$];
            int            occ_m = 0;

            hs_pipe #(
                .DATA_W (8),
                .STAGES (ST)
            ) u_dut (
                .sys_clk   (clk),
                .rst       (rst),
                .flush     (flush[gi]),
                .s_valid   (s_valid[gi]),
                .s_data    (s_data[gi]),
                .s_ready   (sr),
                .m_valid   (mv),
                .m_data    (md),
                .m_ready   (m_ready[gi]),
                .occupancy (occ_w)
            );

            assign s_ready[gi] = sr;
            assign m_valid[gi] = mv;
            assign m_data[gi]  = md;
            assign occ[gi]     = 4'(occ_w);

            always @(negedge clk) begin
                logic [7:0] e;
                if (rst) begin
                    exp_q.delete();
                    occ_m = 0;
                end else begin
                    chk("occupancy_model", gi, occ[gi], occ_m);
                    chk("occupancy_bound", gi, 32'(occ[gi] <= 4'(2 * ST)), 1);
                    if (occ[gi] == 4'd0) chk("empty_no_valid", gi, m_valid[gi], 0);
                    if (occ[gi] == 4'(2 * ST)) chk("full_no_ready", gi, s_ready[gi], 0);
                    if (m_valid[gi] && m_ready[gi]) begin
                        $display("[%0t] inst %0d out 0x%02h", $time, gi, m_data[gi]);
                        if (exp_q.size() == 0) begin
                            chk("unexpected_output", gi, m_data[gi], 32'hFFFF_FFFF);
                        end else begin
                            e = exp_q.pop_front();
                            chk("out_data", gi, m_data[gi], e);
                        end
                    end
                    if (flush[gi]) begin
                        exp_q.delete();
                        occ_m = 0;
                    end else begin
                        if (s_valid[gi] && s_ready[gi]) exp_q.push_back(s_data[gi]);
                        occ_m = occ_m + int'(s_valid[gi] && s_ready[gi]) - int'(m_valid[gi] && m_ready[gi]);
                    end
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one word and wait (bounded) until it is accepted.
    task automatic send(input int i, input logic [7:0] d);
        int k;
        tick();
        s_valid[i] = 1'b1;
        s_data[i]  = d;
        k = 0;
        @(negedge clk);
        while (!s_ready[i] && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (k >= 200) chk("send_timeout", i, 1, 0);
    endtask

    task automatic idle(input int i);
        tick();
        s_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        int k;
        k = 0;
        @(negedge clk);
        while (occ[i] != 4'd0 && k < 200) begin
            k++;
            @(negedge clk);
        end
        if (k >= 200) chk("drain_timeout", i, occ[i], 0);
    endtask

    task automatic rand_src(input int i);
        int   n;
        int   cyc;
        logic pend;
        n = 0; cyc = 0; pend = 1'b0;
        while (n < 1000 && cyc < 30000) begin
            tick();
            cyc++;
            if (!pend) begin
                s_valid[i] = 1'($urandom_range(0, 1));
                s_data[i]  = 8'($urandom);
            end
            @(negedge clk);
            if (s_valid[i] && s_ready[i]) begin
                n++;
                pend = 1'b0;
            end else begin
                pend = s_valid[i];
            end
        end
        tick();
        s_valid[i] = 1'b0;
        chk("rand_words_sent", i, n, 1000);
        src_done[i] = 1'b1;
    endtask

    task automatic rand_sink(input int i);
        int cyc;
        cyc = 0;
        while (!(src_done[i] && occ[i] == 4'd0) && cyc < 35000) begin
            tick();
            m_ready[i] = 1'($urandom_range(0, 1));
            cyc++;
        end
        m_ready[i] = 1'b0;
        chk("rand_drained", i, occ[i], 0);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation still running at %0t, limit 800000", $time);
        $fatal(1);
    end

    initial begin
        int acc;
        for (int i = 0; i < NI; i++) s_data[i] = 8'h00;

        // Reset held two edges while a word is offered.
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h77;
        repeat (2) @(posedge clk);
        #1;
        rst        = 1'b0;
        s_valid[0] = 1'b0;
        @(negedge clk);
        chk("reset_m_valid", 0, m_valid[0], 0);
        chk("reset_occ", 0, occ[0], 0);
        chk("reset_s_ready", 0, s_ready[0], 1);
        @(negedge clk);
        chk("reset_no_emit", 0, m_valid[0], 0);

        // Back-to-back stream 0x01..0x10 with the sink always ready.
        m_ready[0] = 1'b1;
        fork
            begin
                for (int n = 1; n <= 16; n++) send(0, 8'(n));
                idle(0);
            end
            begin
                int k;
                int lat;
                int run;
                k = 0; lat = 0; run = 0;
                @(negedge clk);
                while (!(s_valid[0] && s_ready[0]) && k < 50) begin
                    k++;
                    @(negedge clk);
                end
                @(negedge clk);
                lat = 1;
                while (!m_valid[0] && lat < 50) begin
                    @(negedge clk);
                    lat++;
                end
                chk("stream_latency", 0, lat, 2);
                while (m_valid[0] && run < 40) begin
                    if (run < 15) chk("stream_occ", 0, occ[0], 2);
                    run++;
                    @(negedge clk);
                end
                chk("stream_run_length", 0, run, 16);
            end
        join
        drain(0);

        // Sink stalled: exactly four words fit, head word held steady.
        m_ready[0] = 1'b0;
        acc = 0;
        for (int c = 0; c < 8; c++) begin
            tick();
            s_valid[0] = 1'b1;
            s_data[0]  = 8'hA0 + 8'(acc);
            @(negedge clk);
            if (s_ready[0]) acc++;
            if (m_valid[0]) chk("bp_head_stable", 0, m_data[0], 8'hA0);
        end
        chk("bp_accepted", 0, acc, 4);
        chk("bp_s_ready", 0, s_ready[0], 0);
        chk("bp_occ", 0, occ[0], 4);
        chk("bp_m_valid", 0, m_valid[0], 1);
        chk("bp_m_data", 0, m_data[0], 8'hA0);
        tick();
        s_valid[0] = 1'b0;
        m_ready[0] = 1'b1;
        drain(0);

        // One-cycle sink stall inside a stream of 0x00..0x07; the bubble
        // can close s_ready for at most a single cycle.
        fork
            begin
                for (int n = 0; n < 8; n++) send(0, 8'(n));
                idle(0);
            end
            begin
                repeat (4) @(posedge clk);
                #1 m_ready[0] = 1'b0;
                @(posedge clk);
                #1 m_ready[0] = 1'b1;
            end
            begin
                int low;
                low = 0;
                repeat (14) begin
                    @(negedge clk);
                    if (!s_ready[0]) low++;
                end
                chk("stall_s_ready_low_le1", 0, 32'(low <= 1), 1);
            end
        join
        drain(0);

        // Flush with three words stored and a new word offered.
        m_ready[0] = 1'b0;
        send(0, 8'h30);
        send(0, 8'h31);
        send(0, 8'h32);
        idle(0);
        @(negedge clk);
        chk("flush_pre_occ", 0, occ[0], 3);
        tick();
        flush[0]   = 1'b1;
        s_valid[0] = 1'b1;
        s_data[0]  = 8'h55;
        @(negedge clk);
        chk("flush_offer_ready", 0, s_ready[0], 1);
        tick();
        flush[0]   = 1'b0;
        s_valid[0] = 1'b0;
        @(negedge clk);
        chk("flush_occ", 0, occ[0], 0);
        chk("flush_m_valid", 0, m_valid[0], 0);
        chk("flush_s_ready", 0, s_ready[0], 1);
        m_ready[0] = 1'b1;
        repeat (6) @(negedge clk);
        chk("flush_nothing_emitted", 0, m_valid[0], 0);

        // Random traffic on the STAGES=1 and STAGES=4 instances.
        fork
            rand_src(1);
            rand_src(2);
            rand_sink(1);
            rand_sink(2);
        join

        @(negedge clk);
        chk("queue_empty", 0, g_dut[0].exp_q.size(), 0);
        chk("queue_empty", 1, g_dut[1].exp_q.size(), 0);
        chk("queue_empty", 2, g_dut[2].exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
